// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared constants, record type and helpers for share_reporter; SHARE_HASH_EN adds hash words to records
package miner_pkg;

`ifdef SHARE_HASH_EN
    localparam int SOL_WORDS = 10;
`else
    localparam int SOL_WORDS = 2;
`endif
    localparam int IDX_W            = $clog2(SOL_WORDS);
    localparam int DEF_PIPE_LATENCY = 131;

    typedef enum logic {ST_IDLE, ST_SEND} sol_state_e;

    typedef struct packed {
        logic [31:0]  time_w;
        logic [31:0]  nonce;
`ifdef SHARE_HASH_EN
        logic [255:0] hash;
`endif
    } sol_rec_t;

    function automatic logic [255:0] bswap256(input logic [255:0] v);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = v[8*(31-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/share_reporter_if.sv
// rtl/share_reporter_if.sv - share record word stream with valid/ready handshake
interface share_reporter_if;
    logic        sol_valid;
    logic        sol_ready;
    logic [31:0] sol_data;
    logic        sol_last;

    modport master (output sol_valid, output sol_data, output sol_last, input sol_ready);
    modport slave  (input sol_valid, input sol_data, input sol_last, output sol_ready);
endinterface

// File: rtl/target_expand.sv
// rtl/target_expand.sv - compact target to byte-swapped 256-bit target, combinational
module target_expand
    import miner_pkg::*;
(
    input  logic [31:0]  target_i,
    output logic [255:0] target_sw_o
);
    logic [5:0]   exp_c;
    logic [8:0]   shamt;
    logic [255:0] raw;

    always_comb begin
        // exponents above 32 clamp to a zero shift; exponent 0 yields an unreachable target
        exp_c       = (target_i[7:0] > 8'd32) ? 6'd32 : target_i[5:0];
        shamt       = {6'd32 - exp_c, 3'b000};
        raw         = (exp_c == 6'd0) ? '0 : ({232'd0, target_i[31:8]} << shamt);
        target_sw_o = bswap256(raw);
    end
endmodule

// File: rtl/share_reporter.sv
// rtl/share_reporter.sv - recovers {time,nonce} of hasher results, checks target, streams winning shares (SHARE_HASH_EN adds hash words)
module share_reporter
    import miner_pkg::*;
#(
    parameter int PIPE_LATENCY = DEF_PIPE_LATENCY,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             hash_valid,
    input  logic [255:0]     hash_in,
    input  logic [63:0]      counter_in,
    input  logic [31:0]      target_in,
    share_reporter_if.master sol,
    output logic [CNT_W-1:0] share_count,
    output logic [CNT_W-1:0] drop_count
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SOL_WORDS - 1);

    logic [255:0]     target_sw;
    logic             s1_valid_q;
    logic [255:0]     s1_hash_sw_q;
    logic [255:0]     s1_target_q;
    logic [63:0]      s1_tag_q;
`ifdef SHARE_HASH_EN
    logic [255:0]     s1_hash_raw_q;
    logic [2:0]       hw_idx;
`endif
    sol_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    sol_rec_t         act_q, act_d, pnd_q, pnd_d, new_rec;
    logic             pnd_vld_q, pnd_vld_d;
    logic [CNT_W-1:0] share_q, share_d, drop_q, drop_d;
    logic             hit, hs, finishing, dropped;

    target_expand u_target_expand (
        .target_i    (target_in),
        .target_sw_o (target_sw)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= hash_valid;
        end
        s1_hash_sw_q <= bswap256(hash_in);
        s1_tag_q     <= counter_in - 64'(PIPE_LATENCY);
        s1_target_q  <= target_sw;
`ifdef SHARE_HASH_EN
        s1_hash_raw_q <= hash_in;
`endif
    end

    assign hit = s1_valid_q && (s1_hash_sw_q < s1_target_q);

    always_comb begin
        new_rec        = '0;
        new_rec.time_w = s1_tag_q[63:32];
        new_rec.nonce  = s1_tag_q[31:0];
`ifdef SHARE_HASH_EN
        new_rec.hash   = s1_hash_raw_q;
`endif
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        act_d     = act_q;
        pnd_d     = pnd_q;
        pnd_vld_d = pnd_vld_q;
        share_d   = share_q;
        drop_d    = drop_q;
        dropped   = 1'b0;
        hs        = (state_q == ST_SEND) && sol.sol_ready;
        finishing = hs && (idx_q == LAST_IDX);

        if (hit) begin
            share_d = share_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_SEND;
                    act_d   = new_rec;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                if (hs) begin
                    idx_d = idx_q + IDX_W'(1);
                end
                if (finishing) begin
                    idx_d = '0;
                    // pending moves up; a coincident hit takes the slot it vacates
                    if (pnd_vld_q) begin
                        act_d     = pnd_q;
                        pnd_vld_d = hit;
                        if (hit) begin
                            pnd_d = new_rec;
                        end
                    end else if (hit) begin
                        act_d = new_rec;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (hit) begin
                    if (!pnd_vld_q) begin
                        pnd_d     = new_rec;
                        pnd_vld_d = 1'b1;
                    end else begin
                        dropped = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (dropped && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pnd_vld_q <= 1'b0;
            share_q   <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pnd_vld_q <= pnd_vld_d;
            share_q   <= share_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge CLK) begin
        act_q <= act_d;
        pnd_q <= pnd_d;
    end

`ifdef SHARE_HASH_EN
    assign hw_idx = 3'(4'd9 - 4'(idx_q));
`endif

    always_comb begin
        sol.sol_valid = (state_q == ST_SEND);
        sol.sol_last  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
        sol.sol_data  = '0;
        if (state_q == ST_SEND) begin
            if (idx_q == '0) begin
                sol.sol_data = act_q.time_w;
            end else if (idx_q == IDX_W'(1)) begin
                sol.sol_data = act_q.nonce;
            end
`ifdef SHARE_HASH_EN
            else begin
                sol.sol_data = act_q.hash[{hw_idx, 5'd0} +: 32];
            end
`endif
        end
    end

    assign share_count = share_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_share_reporter.sv
// tb/tb_share_reporter.sv - scoreboard bench for share_reporter with a queue-level reference model
module tb_share_reporter;
`ifdef SHARE_HASH_EN
    localparam int SW = 10;
`else
    localparam int SW = 2;
`endif

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    logic         CLK        = 1'b0;
    logic         RST        = 1'b1;
    logic         hash_valid = 1'b0;
    logic [255:0] hash_in    = '0;
    logic [63:0]  counter_in = '0;
    logic [31:0]  target_in  = 32'hFFFF0020;
    logic [15:0]  share_count;
    logic [15:0]  drop_count;

    share_reporter_if sol_if ();

    share_reporter #(.PIPE_LATENCY(131), .CNT_W(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .hash_valid  (hash_valid),
        .hash_in     (hash_in),
        .counter_in  (counter_in),
        .target_in   (target_in),
        .sol         (sol_if),
        .share_count (share_count),
        .drop_count  (drop_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [255:0] rev(input logic [255:0] v);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = v[255-8*i -: 8];
        return r;
    endfunction

    function automatic bit ref_hit(input logic [255:0] h, input logic [31:0] t);
        int e;
        logic [255:0] tv;
        e = int'(t[7:0]);
        if (e == 0) return 1'b0;
        if (e > 32) e = 32;
        tv = 256'(t[31:8]) << (8 * (32 - e));
        return rev(h) < rev(tv);
    endfunction

    // reference model: records in the two-slot buffer are just a count plus a word queue
    word_t       exp_q[$];
    int          m_occ   = 0;
    int          m_pos   = 0;
    int          m_share = 0;
    int          m_drop  = 0;
    bit          p_hit   = 1'b0;
    logic [31:0] p_words[SW];

    always @(posedge CLK) begin
        bit hs, fin;
        logic [63:0] tag;
        if (RST) begin
            m_occ = 0; m_pos = 0; m_share = 0; m_drop = 0;
            exp_q.delete();
        end else begin
            hs  = (m_occ > 0) && sol_if.sol_ready;
            fin = hs && (m_pos == SW - 1);
            if (p_hit) begin
                m_share++;
                if (m_occ - int'(fin) < 2) begin
                    for (int k = 0; k < SW; k++) exp_q.push_back('{data: p_words[k], last: (k == SW - 1)});
                    m_occ++;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            if (hs) m_pos++;
            if (fin) begin m_occ--; m_pos = 0; end
        end
        p_hit = !RST && hash_valid && ref_hit(hash_in, target_in);
        tag = counter_in - 64'd131;
        p_words[0] = tag[63:32];
        p_words[1] = tag[31:0];
        for (int k = 2; k < SW; k++) p_words[k] = hash_in[255 - 32*(k-2) -: 32];
    end

    // monitor
    int          words_seen = 0;
    int          rec_cnt    = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge CLK) begin
        word_t w;
        chk("sol_valid", 64'(sol_if.sol_valid), 64'(m_occ > 0));
        chk("share_count", 64'(share_count), 64'(m_share[15:0]));
        chk("drop_count", 64'(drop_count), 64'(m_drop[15:0]));
        if (prev_stall) begin
            chk("stall_valid", 64'(sol_if.sol_valid), 64'd1);
            chk("stall_data", 64'(sol_if.sol_data), 64'(prev_data));
            chk("stall_last", 64'(sol_if.sol_last), 64'(prev_last));
        end
        if (sol_if.sol_valid && sol_if.sol_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_word actual=%0h required=none", sol_if.sol_data);
            end else begin
                w = exp_q.pop_front();
                chk("word_data", 64'(sol_if.sol_data), 64'(w.data));
                chk("word_last", 64'(sol_if.sol_last), 64'(w.last));
            end
            words_seen++;
            if (sol_if.sol_last) rec_cnt++;
        end
        prev_stall = sol_if.sol_valid && !sol_if.sol_ready && !RST;
        prev_data  = sol_if.sol_data;
        prev_last  = sol_if.sol_last;
    end

    task automatic cyc(input logic hv, input logic [255:0] h, input logic [63:0] c, input logic rdy);
        hash_valid       = hv;
        hash_in          = h;
        counter_in       = c;
        sol_if.sol_ready = rdy;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc(1'b0, '0, '0, 1'b0);
        RST = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        repeat (3) cyc(1'b0, '0, '0, 1'b1);
        while (m_occ > 0 && n < 400) begin
            cyc(1'b0, '0, '0, 1'b1);
            n++;
        end
        chk("drain_idle", 64'(sol_if.sol_valid), 64'd0);
    endtask

    function automatic logic [255:0] gen_hit();
        logic [255:0] h;
        h = {8{$urandom}};
        h[15:0] = 16'h0000;
        return h;
    endfunction

    initial begin
        logic [255:0] h_eq, h_m1, h;
        logic [63:0]  c;
        int r0, w0, rw;

        sol_if.sol_ready = 1'b0;
        RST = 1'b1;
        repeat (2) cyc(1'b0, '0, '0, 1'b0);
        chk("rst_valid", 64'(sol_if.sol_valid), 64'd0);
        chk("rst_data", 64'(sol_if.sol_data), 64'd0);
        chk("rst_last", 64'(sol_if.sol_last), 64'd0);
        chk("rst_share", 64'(share_count), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        RST = 1'b0;

        // tag back-out and first-record latency
        cyc(1'b1, '0, 64'h00000001_00000005, 1'b0);
        chk("lat_n1_valid", 64'(sol_if.sol_valid), 64'd0);
        cyc(1'b0, '0, '0, 1'b0);
        chk("lat_n2_valid", 64'(sol_if.sol_valid), 64'd1);
        chk("backout_time", 64'(sol_if.sol_data), 64'h00000000);
        cyc(1'b0, '0, '0, 1'b1);
        chk("backout_nonce", 64'(sol_if.sol_data), 64'hFFFFFF82);
        chk("word1_last", 64'(sol_if.sol_last), 64'(SW == 2));
        drain();

        // compare boundaries
        h_eq = 256'h00FFFF00;
        h_m1 = rev(rev(h_eq) - 256'd1);
        r0 = rec_cnt;
        cyc(1'b1, h_eq, 64'd1000, 1'b0); drain();
        chk("eq_share", 64'(share_count), 64'd1);
        chk("eq_records", 64'(rec_cnt - r0), 64'd0);
        cyc(1'b1, h_m1, 64'd2000, 1'b0); drain();
        chk("m1_share", 64'(share_count), 64'd2);
        chk("m1_records", 64'(rec_cnt - r0), 64'd1);
        cyc(1'b1, '1, 64'd3000, 1'b0); drain();
        chk("ones_share", 64'(share_count), 64'd2);
        target_in = 32'hFFFF0000;
        cyc(1'b1, '0, 64'd4000, 1'b0); drain();
        chk("exp0_share", 64'(share_count), 64'd2);
        target_in = 32'hFFFF0021;
        cyc(1'b1, h_m1, 64'd4500, 1'b0); drain();
        chk("clamp_share", 64'(share_count), 64'd3);
        target_in = 32'hFFFF0020;

        // backpressure mid-record
        w0 = words_seen; r0 = rec_cnt;
        cyc(1'b1, gen_hit(), 64'h12345678_9ABCDEF0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1);
        repeat (5) cyc(1'b0, '0, '0, 1'b0);
        drain();
        chk("bp_words", 64'(words_seen - w0), 64'(SW));
        chk("bp_records", 64'(rec_cnt - r0), 64'd1);

        // overflow: two slots, two drops
        do_reset(); r0 = rec_cnt;
        for (int i = 0; i < 4; i++) cyc(1'b1, gen_hit(), 64'(5000 + i), 1'b0);
        repeat (2) cyc(1'b0, '0, '0, 1'b0);
        chk("ovf_share", 64'(share_count), 64'd4);
        chk("ovf_drop", 64'(drop_count), 64'd2);
        drain();
        chk("ovf_records", 64'(rec_cnt - r0), 64'd2);

        // hit coincident with last-word handshake while pending is full
        do_reset(); r0 = rec_cnt;
        cyc(1'b1, gen_hit(), 64'd6000, 1'b0);
        cyc(1'b1, gen_hit(), 64'd6001, 1'b0);
        repeat (2) cyc(1'b0, '0, '0, 1'b0);
        for (int k = 0; k < SW; k++) cyc(k == SW - 2, gen_hit(), 64'(7000 + k), 1'b1);
        drain();
        chk("sim_drop", 64'(drop_count), 64'd0);
        chk("sim_share", 64'(share_count), 64'd3);
        chk("sim_records", 64'(rec_cnt - r0), 64'd3);

        // drop counter saturation
        do_reset();
        for (int i = 0; i < 65540; i++) cyc(1'b1, '0, 64'(i), 1'b0);
        repeat (2) cyc(1'b0, '0, '0, 1'b0);
        chk("sat_drop", 64'(drop_count), 64'hFFFF);
        chk("wrap_share", 64'(share_count), 64'd4);
        drain();

        // reset in the middle of a record
        do_reset(); r0 = rec_cnt;
        rw = (SW > 4) ? 3 : SW - 1;
        cyc(1'b1, gen_hit(), 64'd8000, 1'b0);
        cyc(1'b0, '0, '0, 1'b0);
        for (int j = 0; j < rw; j++) cyc(1'b0, '0, '0, 1'b1);
        chk("mid_valid", 64'(sol_if.sol_valid), 64'd1);
        RST = 1'b1;
        cyc(1'b0, '0, '0, 1'b0);
        RST = 1'b0;
        chk("midrst_valid", 64'(sol_if.sol_valid), 64'd0);
        chk("midrst_share", 64'(share_count), 64'd0);
        chk("midrst_drop", 64'(drop_count), 64'd0);
        cyc(1'b1, gen_hit(), 64'd9000, 1'b0);
        drain();
        chk("midrst_records", 64'(rec_cnt - r0), 64'd1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            h = {8{$urandom}};
            if ($urandom % 2 == 0) h[7:0] = 8'h00;
            c = ($urandom % 8 == 0) ? 64'($urandom_range(0, 200)) : {$urandom, $urandom};
            cyc(($urandom % 3) != 0, h, c, ($urandom % 4) != 0);
        end
        drain();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/share_reporter.md
# share_reporter

Downstream stage of `sha_hasher`. It takes every double-SHA result the hasher emits and recovers the `{time, nonce}` that produced it by subtracting the pipeline latency. It checks the byte-swapped hash against the expanded compact target and serializes each winning share as a word stream with a valid/ready handshake. It replaces the hasher's stop-on-first-hit behaviour with continuous reporting: one record in flight, one pending, overflow counted.

## Interface
Parameters:
- `PIPE_LATENCY`, 131, cycles from counter increment to matching `hash_valid`; subtracted from `counter_in`.
- `CNT_W`, 16, width of the statistics counters.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `hash_valid`  in  1  `hash_in` and `counter_in` valid this cycle.
- `hash_in`  in  256  hasher `result_out`, raw byte order.
- `counter_in`  in  64  hasher `{time, nonce}` counter sampled in the same cycle.
- `target_in`  in  32  compact target: mantissa `[31:8]`, exponent `[7:0]`; static while mining.
- `sol_ready`  in  1  consumer accepts `sol_data`.
- `sol_valid`  out  1  `sol_data` holds a record word.
- `sol_data`  out  32  record word.
- `sol_last`  out  1  final word of the record.
- `share_count`  out  `CNT_W`  hits detected; wraps.
- `drop_count`  out  `CNT_W`  hits lost to a full buffer; saturates at all-ones.

## Operation
- Stage S1, registered: byte-reverse `hash_in`; back out the tag as `counter_in - PIPE_LATENCY` in full 64-bit arithmetic (a nonce borrow decrements time, and 0 wraps to 2^64-1); expand the target.
- Target expansion: `mantissa << 8*(32-exp)` in 256 bits, then byte-reversed. exp=0 gives 0, so nothing passes. exp>32 clamps to 32 (shift 0).
- Stage S2: hit = S1 valid && swapped hash < swapped target, strictly unsigned. An equal value is a miss.
- Buffer: `active` (being serialized) and `pending` slots.
  - A hit goes to `active` if it is free or finishing this cycle with `pending` empty. Otherwise it goes to `pending` if that is free or moving to `active` this cycle. Otherwise it is dropped and `drop_count++`.
  - Every hit, dropped or not, increments `share_count`.
- Record, `SOL_WORDS` words: word0 = time, word1 = nonce, then (if `SHARE_HASH_EN`) words 2..9 = `hash_in[255:224]` down to `[31:0]`, unswapped.
- Serializer FSM:
  - IDLE: `sol_valid`=0. Goes to SEND when `active` loads.
  - SEND: word index advances on `sol_valid && sol_ready`. On the last-word handshake it reloads from `pending` (stays in SEND) or goes to IDLE.
- `sol_data`, `sol_last` and the word index hold steady while `sol_valid && !sol_ready`.
- Reset values: `sol_valid`=0, `sol_data`=0, `sol_last`=0, both counters 0, both slots empty, S1/S2 valids 0, FSM IDLE.
- RST mid-record abandons the record. No partial-record recovery.

## Timing
- `hash_valid` at cycle N: S1 registered at end of N, hit decision in N+1, `active` loaded at end of N+1. `sol_valid` is high in N+2 with word0.
- Back-to-back hits at full rate (one per cycle): both are accepted only if both slots are free. The third is dropped unless a last-word handshake coincides.
- A record needs ≥`SOL_WORDS` cycles. Streaming throughput is one word/cycle with `sol_ready` held high.
- A new record can start the cycle after a `sol_last` handshake, with no bubble when `pending` is full.
- `share_count` and `drop_count` update at end of N+1.

## Configuration
- `SHARE_HASH_EN` defined: `SOL_WORDS`=10, hash words included, `hash_in` pipelined into both slots.
- `SHARE_HASH_EN` undefined: `SOL_WORDS`=2 (time, nonce), `sol_last` on word1, and no hash storage (saves ~768 flops). Compare logic is unchanged.

## Structure
- `miner_pkg` holds: `SOL_WORDS`, default `PIPE_LATENCY`, `bswap256` function, FSM state enum (`ST_IDLE`, `ST_SEND`), `sol_rec_t` record struct.
- Sub-module `target_expand`: combinational compact-to-swapped-256-bit target, shareable with the hasher's own check.

## Test plan
- Back-out: `counter_in`=64'h00000001_00000005, PIPE_LATENCY=131, `target_in`=32'hFFFF0020, `hash_in`=0 → record word0=32'h00000000, word1=32'hFFFFFF82, `sol_valid` rises 2 cycles after `hash_valid`.
- Compare boundaries: `target_in`=32'hFFFF0020, `hash_in` swapped equal to target → no record, `share_count` unchanged. Target minus 1 → one record. `hash_in`=all-ones → none. exp=0 → never a hit.
- Backpressure: hold `sol_ready`=0 for 5 cycles mid-record → `sol_data` stable, no words lost, `sol_last` asserted exactly once on word `SOL_WORDS-1`.
- Overflow: 4 consecutive hits with `sol_ready`=0 → 2 records eventually delivered in order, `share_count`=4, `drop_count`=2. Drive 2^16+ drops → `drop_count` holds 16'hFFFF.
- Simultaneous: hit in the same cycle as the last-word handshake with `pending` full → `pending` streams next with no bubble, new hit lands in `pending`, `drop_count` unchanged.
- Reset: assert RST during word 3 → next cycle `sol_valid`=0, counters 0. A later hit produces a complete fresh record starting at word0.
